// File: rtl/pc_seq.sv
// Multi-cycle program-counter sequencer: fetches one instruction over a
// valid/ready request + valid response port, holds it for execute, then commits the next PC.
module pc_seq #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            exec_done,
    input  logic            halt_req,
    output logic            if_req_valid,
    input  logic            if_req_ready,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_resp_valid,
    input  logic [31:0]     if_resp_data,
    input  logic            if_resp_err,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     retire_cnt
);

    // Handshake: a fetch request transfers on the cycle where if_req_valid and
    // if_req_ready are both high; valid/addr hold until then. Responses are
    // only honoured in WAIT_RESP, one per request.
    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_EXEC      = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            fault_q, fault_d;
    logic [31:0]     retire_q, retire_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] jalr_tgt;

    assign jalr_tgt = rs1 + imm;

    always_comb begin
        next_pc = pc_q + XLEN'(4);
        case (pc_src)
            2'b00:   next_pc = pc_q + XLEN'(4);
            2'b01:   next_pc = pc_q + imm;
            2'b10:   next_pc = {jalr_tgt[XLEN-1:1], 1'b0};
            default: next_pc = csr_pc;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        fault_d  = fault_q;
        retire_d = retire_q;
        case (state_q)
            S_FETCH: begin
                if (if_req_ready) begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (if_resp_valid) begin
                    if (if_resp_err) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        inst_d  = if_resp_data;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // The instruction retires even when it halts or lands on a bad target.
                if (exec_done) begin
                    retire_d = retire_q + 32'd1;
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            inst_q   <= 32'd0;
            fault_q  <= 1'b0;
            retire_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            fault_q  <= fault_d;
            retire_q <= retire_d;
        end
    end

    // Request is masked while rst is high so nothing leaks out during the reset cycle.
    assign if_req_valid = (state_q == S_FETCH) && !rst;
    assign if_req_addr  = pc_q;
    assign pc           = pc_q;
    assign inst         = inst_q;
    assign inst_valid   = (state_q == S_EXEC);
    assign halted       = (state_q == S_HALT);
    assign fault        = fault_q;
    assign retire_cnt   = retire_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed vector table, hand-written corner sequences and
// randomized instruction streams checked against an architectural model.
module tb_pc_seq;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_src = '0;
  logic [31:0] imm = '0, rs1 = '0, csr_pc = '0;
  logic        exec_done = 1'b0, halt_req = 1'b0;
  logic        if_req_valid, if_req_ready = 1'b0;
  logic [31:0] if_req_addr;
  logic        if_resp_valid = 1'b0;
  logic [31:0] if_resp_data = '0;
  logic        if_resp_err = 1'b0;
  logic [31:0] pc, inst, retire_cnt;
  logic        inst_valid, halted, fault;

  pc_seq dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .imm(imm), .rs1(rs1), .csr_pc(csr_pc),
    .exec_done(exec_done), .halt_req(halt_req),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .halted(halted), .fault(fault),
    .retire_cnt(retire_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  int vec_cnt = 0;
  int miss_cnt = 0;

  // architectural reference model
  logic [31:0] m_pc, m_inst, m_retire;
  bit          m_halted, m_fault;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm_v;
    logic [31:0] rs1_v;
    logic [31:0] csr_v;
    bit          halt;
    logic [31:0] exp_pc;
    bit          exp_halted;
    bit          exp_fault;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                           input logic [31:0] imm_v, input logic [31:0] rs1_v,
                                           input logic [31:0] csr_v);
    case (src)
      2'd0:    return cur + 32'd4;
      2'd1:    return cur + imm_v;
      2'd2:    return (rs1_v + imm_v) & 32'hffff_fffe;
      default: return csr_v;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    exec_done = 1'b0;
    halt_req  = 1'($urandom_range(0, 1));
    pc_src    = 2'($urandom_range(0, 3));
    imm       = $urandom;
    rs1       = $urandom;
    csr_pc    = $urandom;
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_retire"}, retire_cnt, m_retire);
    check({tag, "_halted"}, 32'(halted), 32'(m_halted));
    check({tag, "_fault"}, 32'(fault), 32'(m_fault));
  endtask

  // driver: synchronous reset
  task automatic do_reset();
    rst = 1'b1;
    if_req_ready  = 1'($urandom_range(0, 1));
    if_resp_valid = 1'b0;
    if_resp_err   = 1'b0;
    idle_inputs();
    tick();
    check("rst_req_valid", 32'(if_req_valid), 32'd0);
    tick();
    m_pc = RST_PC; m_inst = 32'd0; m_retire = 32'd0; m_halted = 0; m_fault = 0;
    check_arch("rst");
    check("rst_inst", inst, 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_req_valid2", 32'(if_req_valid), 32'd0);
    rst = 1'b0;
    if_req_ready = 1'b0;
    #1;
    check("resume_req_valid", 32'(if_req_valid), 32'd1);
    check("resume_req_addr", if_req_addr, RST_PC);
  endtask

  // driver: one fetch transaction with configurable backpressure
  task automatic run_fetch(input logic [31:0] data, input int rdy_dly, input int rsp_dly,
                           input bit spur, input bit err);
    int n = 0;
    while (!if_req_valid && n < 50) begin
      tick();
      n++;
    end
    check("req_valid", 32'(if_req_valid), 32'd1);
    check("req_addr", if_req_addr, m_pc);
    if_resp_data = 32'hdead_beef;
    if_resp_err  = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      if_req_ready  = 1'b0;
      if_resp_valid = spur;
      tick();
      check("req_hold_valid", 32'(if_req_valid), 32'd1);
      check("req_hold_addr", if_req_addr, m_pc);
    end
    if_req_ready  = 1'b1;
    if_resp_valid = spur;
    tick();
    if_req_ready  = 1'b0;
    if_resp_valid = 1'b0;
    check("req_drop", 32'(if_req_valid), 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      check("wait_no_exec", 32'(inst_valid), 32'd0);
      check("wait_no_req", 32'(if_req_valid), 32'd0);
    end
    if_resp_valid = 1'b1;
    if_resp_data  = data;
    if_resp_err   = err;
    tick();
    if_resp_valid = 1'b0;
    if_resp_err   = 1'b0;
    if_resp_data  = $urandom;
    if (err) begin
      m_halted = 1; m_fault = 1;
      check("err_no_exec", 32'(inst_valid), 32'd0);
    end else begin
      m_inst = data;
      check("exec_valid", 32'(inst_valid), 32'd1);
    end
    check("fetch_inst", inst, m_inst);
    check_arch("fetch");
  endtask

  // driver: execute phase; inputs are only meaningful on the exec_done cycle
  task automatic run_exec(input logic [1:0] src, input logic [31:0] imm_v, input logic [31:0] rs1_v,
                          input logic [31:0] csr_v, input bit halt, input int dly);
    logic [31:0] nxt;
    for (int i = 0; i < dly; i++) begin
      idle_inputs();
      tick();
      check("exec_hold_valid", 32'(inst_valid), 32'd1);
      check("exec_hold_inst", inst, m_inst);
      check("exec_hold_pc", pc, m_pc);
    end
    exec_done = 1'b1;
    pc_src = src; imm = imm_v; rs1 = rs1_v; csr_pc = csr_v; halt_req = halt;
    tick();
    idle_inputs();
    m_retire = m_retire + 32'd1;
    if (halt) begin
      m_halted = 1;
    end else begin
      nxt = ref_next(m_pc, src, imm_v, rs1_v, csr_v);
      if (nxt[1:0] != 2'b00) begin
        m_halted = 1; m_fault = 1;
      end else begin
        m_pc = nxt;
      end
    end
    check("exec_end_valid", 32'(inst_valid), 32'd0);
    check("exec_req_valid", 32'(if_req_valid), 32'(!m_halted));
    check_arch("exec");
  endtask

  // HALT must be absorbing whatever the inputs do
  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      exec_done     = 1'($urandom_range(0, 1));
      if_req_ready  = 1'($urandom_range(0, 1));
      if_resp_valid = 1'($urandom_range(0, 1));
      if_resp_err   = 1'($urandom_range(0, 1));
      tick();
      check("halt_no_req", 32'(if_req_valid), 32'd0);
      check("halt_no_exec", 32'(inst_valid), 32'd0);
      check("halt_inst", inst, m_inst);
      check_arch("halt");
    end
    exec_done = 1'b0; if_req_ready = 1'b0; if_resp_valid = 1'b0; if_resp_err = 1'b0;
  endtask

  initial begin
    int last_cyc;
    bit err;
    tbl[0] = '{2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h8000_0004, 1'b0, 1'b0};
    tbl[1] = '{2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h8000_0008, 1'b0, 1'b0};
    tbl[2] = '{2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h8000_000c, 1'b0, 1'b0};
    tbl[3] = '{2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h8000_0010, 1'b0, 1'b0};
    tbl[4] = '{2'd1, 32'hffff_fff8, 32'h0, 32'h0, 1'b0, 32'h8000_0008, 1'b0, 1'b0};
    tbl[5] = '{2'd2, 32'h0000_0003, 32'h8000_0101, 32'h0, 1'b0, 32'h8000_0104, 1'b0, 1'b0};
    tbl[6] = '{2'd3, 32'h0, 32'h0, 32'h8000_0200, 1'b0, 32'h8000_0200, 1'b0, 1'b0};
    tbl[7] = '{2'd3, 32'h0, 32'h0, 32'h8000_0202, 1'b0, 32'h8000_0200, 1'b1, 1'b1};

    do_reset();
    last_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      run_fetch($urandom, 0, 0, 1'b0, 1'b0);
      run_exec(tbl[i].src, tbl[i].imm_v, tbl[i].rs1_v, tbl[i].csr_v, tbl[i].halt, 0);
      check("tbl_pc", pc, tbl[i].exp_pc);
      check("tbl_halted", 32'(halted), 32'(tbl[i].exp_halted));
      check("tbl_fault", 32'(fault), 32'(tbl[i].exp_fault));
      check("tbl_retire", retire_cnt, 32'(i + 1));
      if (i < 4) check("tbl_period", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
    end
    halt_hold(3);

    // backpressure with spurious responses in FETCH
    do_reset();
    run_fetch(32'h1234_5678, 4, 5, 1'b1, 1'b0);
    check("bp_inst", inst, 32'h1234_5678);
    run_exec(2'd0, $urandom, $urandom, $urandom, 1'b0, 2);
    check("bp_pc", pc, 32'h8000_0004);
    check("bp_one_exec", 32'(inst_valid), 32'd0);

    // fetch error
    do_reset();
    run_fetch(32'h0bad_0bad, 1, 2, 1'b0, 1'b1);
    check("err_pc", pc, RST_PC);
    halt_hold(4);

    // ebreak
    do_reset();
    run_fetch(32'h0010_0073, 0, 0, 1'b0, 1'b0);
    run_exec(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    check("ebreak_fault", 32'(fault), 32'd0);
    halt_hold(20);

    // reset mid-WAIT_RESP
    do_reset();
    run_fetch($urandom, 0, 0, 1'b0, 1'b0);
    run_exec(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    if_req_ready = 1'b1;
    tick();
    if_req_ready = 1'b0;
    check("mid_wait_state", 32'(if_req_valid), 32'd0);
    do_reset();
    // reset mid-EXEC
    run_fetch($urandom, 0, 0, 1'b0, 1'b0);
    run_exec(2'd1, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 0);
    run_fetch($urandom, 0, 1, 1'b0, 1'b0);
    do_reset();

    // randomized instruction streams
    for (int k = 0; k < 200; k++) begin
      logic [1:0]  src;
      logic [31:0] imm_v, rs1_v, csr_v;
      if (m_halted) begin
        halt_hold($urandom_range(1, 4));
        do_reset();
      end
      err = ($urandom_range(0, 39) == 0);
      run_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), err);
      if (!m_halted) begin
        src   = 2'($urandom_range(0, 3));
        imm_v = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hffff_fffc);
        rs1_v = ($urandom & 32'hffff_fffc) | 32'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) rs1_v = rs1_v | 32'h2;
        csr_v = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hffff_fffc);
        run_exec(src, imm_v, rs1_v, csr_v, ($urandom_range(0, 15) == 0), $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
